wb_conmax_slv_arb: RTL and testbench

//  Per-slave-port arbiter for the 8-master x 16-slave WISHBONE interconnect.
//  - Selects which master owns one slave port; one instance per slave (16 total).
//  - Priority levels come from the interconnect's config registers.
//  - Round-robin is used among equal-priority requesters.
//  - Holds ownership for the full bus cycle (CYC); a watchdog frees a hung slave.

---
 rtl/wb_conmax_pkg.sv | 26 ++
 rtl/wb_conmax_rr_pick.sv | 31 +++
 rtl/wb_conmax_slv_arb.sv | 127 ++++++++++++
 tb/tb_wb_conmax_slv_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_conmax_pkg.sv
// Shared types and helpers for the WISHBONE interconnect slave-port arbiter.
//   NUM_MST     : number of masters (fixed at 8, 3-bit index)
//   mst_idx_t   : master index
//   pri_t       : per-master priority level (up to 2 bits)
//   arb_state_e : arbiter state (IDLE / OWN)
//   onehot()    : index -> one-hot master vector
package wb_conmax_pkg;

    localparam int NUM_MST = 8;

    typedef logic [2:0] mst_idx_t;
    typedef logic [1:0] pri_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_MST-1:0] onehot(mst_idx_t idx);
        logic [NUM_MST-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_conmax_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector, already filtered to the winning priority level
//   ptr_i    : last winner at this level; the search starts at ptr_i+1 and wraps 7->0
//   winner_o : first asserted request found
//   found_o  : any request asserted
module wb_conmax_rr_pick
    import wb_conmax_pkg::*;
(
    input  logic [NUM_MST-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [2:0]         winner_o,
    output logic               found_o
);

    mst_idx_t idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit is written last.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int i = NUM_MST; i >= 1; i--) begin
            idx = ptr_i + 3'(i);
            if (req_i[idx]) begin
                winner_o = idx;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_conmax_slv_arb.sv
// Per-slave-port arbiter for the 8-master x 16-slave WISHBONE interconnect.
// Highest priority wins; round-robin among equals; ownership held for the whole
// bus cycle, with a watchdog that forces release of a hung slave.
//   clk_i     : interconnect clock
//   rst_i     : asynchronous reset, active-low
//   req_i     : per-master request (cyc & address hit)
//   pri_i     : per-master priority, master m at [m*PRI_BITS +: PRI_BITS]
//   term_i    : slave ack|err|rty this cycle
//   gnt_o     : owning master index
//   gnt_vld_o : gnt_o valid
//   gnt_oh_o  : one-hot grant, zero when not valid
//   timeout_o : one-cycle pulse on watchdog release
module wb_conmax_slv_arb #(
    parameter int unsigned NUM_MST  = 8,
    parameter int unsigned PRI_BITS = 2,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MST-1:0]          req_i,
    input  logic [NUM_MST*PRI_BITS-1:0] pri_i,
    input  logic                        term_i,
    output logic [2:0]                  gnt_o,
    output logic                        gnt_vld_o,
    output logic [NUM_MST-1:0]          gnt_oh_o,
    output logic                        timeout_o
);
    import wb_conmax_pkg::*;

    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e         state_q;
    mst_idx_t           gnt_q;
    logic               vld_q;
    logic [NUM_MST-1:0] oh_q;
    logic               timeout_q;
    logic [WdW-1:0]     wd_q;
    logic [NUM_MST-1:0] mask_q;     // timed-out masters, blocked until their req drops
    mst_idx_t           rr_ptr_q [4];

    logic               owner_req;
    logic               release_now;
    logic               wd_fire;
    logic               arb_en;
    logic [NUM_MST-1:0] excl;
    logic [NUM_MST-1:0] elig;
    logic [NUM_MST-1:0] lvl_req;
    pri_t               max_pri;
    mst_idx_t           winner;
    logic               found;

    assign owner_req   = req_i[gnt_q];
    assign release_now = (state_q == OWN) && !owner_req;
    // Normal release takes precedence: wd_fire requires the owner still requesting.
    assign wd_fire     = (TIMEOUT != 0) && (state_q == OWN) && owner_req && !term_i &&
                         (wd_q == WdW'(TIMEOUT - 1));
    assign arb_en      = (state_q == IDLE) || release_now || wd_fire;

    // Reduce requests to those at the highest asserted priority level.
    always_comb begin
        excl = mask_q;
        if (wd_fire) begin
            excl[gnt_q] = 1'b1;
        end
        elig    = req_i & ~excl;
        max_pri = '0;
        for (int m = 0; m < NUM_MST; m++) begin
            if (elig[m] && (pri_t'(pri_i[m*PRI_BITS +: PRI_BITS]) > max_pri)) begin
                max_pri = pri_t'(pri_i[m*PRI_BITS +: PRI_BITS]);
            end
        end
        lvl_req = '0;
        for (int m = 0; m < NUM_MST; m++) begin
            lvl_req[m] = elig[m] && (pri_t'(pri_i[m*PRI_BITS +: PRI_BITS]) == max_pri);
        end
    end

    wb_conmax_rr_pick u_pick (
        .req_i    (lvl_req),
        .ptr_i    (rr_ptr_q[max_pri]),
        .winner_o (winner),
        .found_o  (found)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            vld_q     <= 1'b0;
            oh_q      <= '0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            mask_q    <= '0;
            for (int l = 0; l < 4; l++) begin
                rr_ptr_q[l] <= 3'(NUM_MST - 1);
            end
        end else begin
            timeout_q <= 1'b0;
            mask_q    <= (mask_q & req_i) | (wd_fire ? onehot(gnt_q) : '0);
            if (arb_en) begin
                wd_q <= '0;
                if (found) begin
                    state_q           <= OWN;
                    gnt_q             <= winner;
                    vld_q             <= 1'b1;
                    oh_q              <= onehot(winner);
                    rr_ptr_q[max_pri] <= winner;
                end else begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    oh_q    <= '0;
                end
                if (wd_fire) begin
                    timeout_q <= 1'b1;
                end
            end else if (state_q == OWN) begin
                wd_q <= term_i ? '0 : wd_q + 1'b1;
            end
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = vld_q;
    assign gnt_oh_o  = oh_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_conmax_slv_arb.sv
module tb_wb_conmax_slv_arb;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [15:0] pri;
    logic        term;
    logic [2:0]  gnt;
    logic        gnt_vld;
    logic [7:0]  gnt_oh;
    logic        timeout;

    int n_pass  = 0;
    int n_total = 0;

    wb_conmax_slv_arb #(
        .NUM_MST  (8),
        .PRI_BITS (2),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .req_i     (req),
        .pri_i     (pri),
        .term_i    (term),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_oh_o  (gnt_oh),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index, watchdog count, last winner per level, blocked masters.
    int         m_gnt;
    bit         m_vld;
    bit         m_to;
    int         m_wd;
    int         m_ptr [4];
    logic [7:0] m_mask;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_gnt  = 0;
        m_vld  = 0;
        m_to   = 0;
        m_wd   = 0;
        m_mask = '0;
        for (int l = 0; l < 4; l++) m_ptr[l] = 7;
    endfunction

    function automatic int pri_of(logic [15:0] p, int m);
        logic [1:0] v;
        v = p[2*m +: 2];
        return int'(v);
    endfunction

    function automatic void model_step(logic [7:0] r, logic [15:0] p, logic t);
        bit         fire;
        bit         arb;
        logic [7:0] cand;
        logic [7:0] nmask;
        int         best;
        int         idx;
        fire = 0;
        arb  = 0;
        m_to = 0;
        if (m_vld) begin
            if (!r[m_gnt]) arb = 1;
            else if (t) m_wd = 0;
            else if (m_wd == TO - 1) begin
                fire = 1;
                arb  = 1;
            end else m_wd++;
        end else begin
            arb = 1;
        end
        nmask = m_mask & r;
        if (fire) nmask[m_gnt] = 1'b1;
        if (arb) begin
            cand = r & ~m_mask;
            if (fire) cand[m_gnt] = 1'b0;
            if (cand == 8'h00) begin
                m_vld = 0;
            end else begin
                best = -1;
                for (int m = 0; m < 8; m++)
                    if (cand[m] && pri_of(p, m) > best) best = pri_of(p, m);
                for (int k = 1; k <= 8; k++) begin
                    idx = (m_ptr[best] + k) % 8;
                    if (cand[idx] && pri_of(p, idx) == best) begin
                        m_gnt = idx;
                        break;
                    end
                end
                m_ptr[best] = m_gnt;
                m_vld       = 1;
                m_wd        = 0;
            end
            m_to = fire;
        end
        m_mask = nmask;
    endfunction

    function automatic logic [12:0] model_vec();
        logic [7:0] oh;
        logic [2:0] g;
        oh = 8'h00;
        g  = 3'b000;
        if (m_vld) begin
            g     = m_gnt[2:0];
            oh[g] = 1'b1;
        end
        return {m_to, m_vld, g, oh};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {timeout, gnt_vld, gnt_vld ? gnt : 3'b000, gnt_oh};
    endfunction

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic [7:0] r, input logic [15:0] p, input logic t);
        req  = r;
        pri  = p;
        term = t;
        model_step(r, p, t);
        @(posedge clk);
        #1;
        check("model", 16'(dut_vec()), 16'(model_vec()));
    endtask

    task automatic expect_out(input string name, input logic v, input logic [2:0] g,
                              input logic to);
        check(name, 16'({timeout, gnt_vld, gnt_vld ? gnt : 3'b000}),
              16'({to, v, v ? g : 3'b000}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        pri   = '0;
        term  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", 16'({timeout, gnt_vld, gnt, gnt_oh}), 16'h0000);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic [15:0] pri;
        logic       term;
        logic       exp_vld;
        logic [2:0] exp_gnt;
        logic       exp_to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rs, input logic [7:0] r, input logic [15:0] p, input logic t,
                       input logic v, input logic [2:0] g, input logic to);
        vec_t e;
        e.rst = rs; e.req = r; e.pri = p; e.term = t;
        e.exp_vld = v; e.exp_gnt = g; e.exp_to = to;
        tbl.push_back(e);
    endtask

    initial begin
        logic [7:0]  r;
        logic [31:0] rnd;
        logic        t;

        rst_n = 1'b0;
        req   = '0;
        pri   = '0;
        term  = 1'b0;

        // Single requester: 1-clk grant latency, release on req drop.
        add(1, 8'h01, 16'h0000, 0, 1, 3'd0, 0);
        add(0, 8'h00, 16'h0000, 0, 0, 3'd0, 0);
        // Equal priority, everyone requesting, 2-clk ownership: 0..7,0 with no gaps.
        add(1, 8'hFF, 16'h0000, 0, 1, 3'd0, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 8'hFF, 16'h0000, 0, 1, 3'(i), 0);
            add(0, ~(8'h01 << i), 16'h0000, 0, 1, 3'((i + 1) % 8), 0);
        end
        // m5 at priority 3, others at 1: m5 first, then round-robin without m5.
        add(1, 8'hFF, 16'h5D55, 0, 1, 3'd5, 0);
        add(0, 8'hDF, 16'h5D55, 0, 1, 3'd0, 0);
        add(0, 8'hDE, 16'h5D55, 0, 1, 3'd1, 0);
        add(0, 8'hDC, 16'h5D55, 0, 1, 3'd2, 0);
        add(0, 8'hD8, 16'h5D55, 0, 1, 3'd3, 0);
        add(0, 8'hD0, 16'h5D55, 0, 1, 3'd4, 0);
        add(0, 8'hC0, 16'h5D55, 0, 1, 3'd6, 0);
        add(0, 8'h80, 16'h5D55, 0, 1, 3'd7, 0);
        add(0, 8'h00, 16'h5D55, 0, 0, 3'd0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].req, tbl[i].pri, tbl[i].term);
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_vld, tbl[i].exp_gnt, tbl[i].exp_to);
        end

        // Watchdog: m2 hangs, m3 waiting.
        do_reset();
        cycle(8'h04, 16'h0000, 0);
        expect_out("wd_grant", 1, 3'd2, 0);
        for (int k = 1; k < TO; k++) begin
            cycle(8'h0C, 16'h0000, 0);
            expect_out($sformatf("wd_hold%0d", k), 1, 3'd2, 0);
        end
        cycle(8'h0C, 16'h0000, 0);
        expect_out("wd_fire", 1, 3'd3, 1);
        cycle(8'h0C, 16'h0000, 1);
        expect_out("wd_pulse_end", 1, 3'd3, 0);
        cycle(8'h04, 16'h0000, 0);
        expect_out("wd_masked0", 0, 3'd0, 0);
        cycle(8'h04, 16'h0000, 0);
        expect_out("wd_masked1", 0, 3'd0, 0);
        cycle(8'h00, 16'h0000, 0);
        expect_out("wd_unmask", 0, 3'd0, 0);
        cycle(8'h04, 16'h0000, 0);
        expect_out("wd_regrant", 1, 3'd2, 0);

        // Priority change during ownership is ignored until the next arbitration.
        do_reset();
        cycle(8'h08, 16'h0000, 0);
        expect_out("pri_own", 1, 3'd3, 0);
        cycle(8'h58, 16'h3000, 0);
        expect_out("pri_hold0", 1, 3'd3, 0);
        cycle(8'h58, 16'h3000, 1);
        expect_out("pri_hold1", 1, 3'd3, 0);
        cycle(8'h50, 16'h3000, 0);
        expect_out("pri_next", 1, 3'd6, 0);

        // Asynchronous reset while owning.
        do_reset();
        cycle(8'h01, 16'h0000, 0);
        expect_out("ar_own", 1, 3'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", 16'({timeout, gnt_vld, gnt, gnt_oh}), 16'h0000);
        model_reset();
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(8'h0C, 16'h0000, 0);
        expect_out("ar_after", 1, 3'd2, 0);

        // Randomized traffic against the model, alternating busy and hung-slave phases.
        do_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 8; m++)
                if ($urandom_range(0, 9) == 0) r[m] = ~r[m];
            rnd = $urandom;
            if (((c / 200) % 2) == 0) t = ($urandom_range(0, 2) == 0);
            else t = ($urandom_range(0, 39) == 0);
            cycle(r, rnd[15:0], t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
